// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and the byte-serial reflected CRC-32 step
// used by the frame-aware CRC engine.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } crc_state_e;

   // One byte folded LSB-first into a reflected CRC-32 register.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
      logic [31:0] c;
      c = crc ^ {24'h000000, data_byte};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = {1'b0, c[31:1]} ^ CRC32_POLY_REFL;
         end else begin
            c = {1'b0, c[31:1]};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_fold_dw.sv
// Combinational whole-beat CRC update: folds the enabled bytes of one beat,
// byte 0 first, into the incoming CRC register value.
module crc32_fold_dw
   import crc32_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]         crc_in,
   input  logic [DATA_W/8-1:0] keep,
   input  logic [DATA_W-1:0]   data,
   output logic [31:0]         crc_out
);

   localparam int KEEP_W = DATA_W / 8;

   // Unrolled byte chain; disabled bytes pass the running value through.
   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < KEEP_W; i++) begin
         if (keep[i]) begin
            crc_out = crc32_byte(crc_out, data[8*i +: 8]);
         end else begin
            crc_out = crc_out;
         end
      end
   end

endmodule

// File: rtl/crc32_dw_frame.sv
// Frame-aware Ethernet CRC-32 engine: tracks sop/eop framing, produces the
// on-wire FCS in generate mode and a residue check in check mode.
module crc32_dw_frame
   import crc32_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter logic [31:0] CRC_INIT = CRC32_INIT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                crc_clr,
   input  logic                mode,
   input  logic                s_valid,
   input  logic                s_sop,
   input  logic                s_eop,
   input  logic [DATA_W/8-1:0] s_keep,
   input  logic [DATA_W-1:0]   s_data,
   output logic [31:0]         crc_state,
   output logic                fcs_valid,
   output logic [31:0]         fcs,
   output logic                fcs_ok,
   output logic                proto_err
);

   localparam int                KEEP_W    = DATA_W / 8;
   localparam logic [KEEP_W-1:0] KEEP_ONE  = KEEP_W'(1'b1);
   localparam logic [KEEP_W-1:0] KEEP_ALL  = {KEEP_W{1'b1}};
   localparam logic [KEEP_W-1:0] KEEP_NONE = {KEEP_W{1'b0}};

   crc_state_e        state_q, state_d;
   logic [31:0]       crc_q, crc_d;
   logic [31:0]       fcs_q, fcs_d;
   logic              mode_q, mode_d;
   logic              fcs_valid_q, fcs_valid_d;
   logic              fcs_ok_q, fcs_ok_d;
   logic              proto_err_q, proto_err_d;

   logic [KEEP_W-1:0] keep_lsb_s;
   logic [KEEP_W-1:0] keep_run_s;
   logic              keep_therm_s;
   logic              keep_legal_s;
   logic              mode_eff_s;
   logic [31:0]       crc_start_s;
   logic [31:0]       crc_fold_s;

   // Keep decode: the lowest contiguous run of set bits is what gets folded,
   // so a malformed keep still folds a well-defined prefix of bytes.
   always_comb begin
      keep_lsb_s   = s_keep & (~s_keep + KEEP_ONE);
      keep_run_s   = s_keep & ~(s_keep + keep_lsb_s);
      keep_therm_s = ((s_keep + KEEP_ONE) & s_keep) == KEEP_NONE;
      if (s_eop) begin
         keep_legal_s = keep_therm_s;
      end else begin
         keep_legal_s = (s_keep == KEEP_ALL);
      end
      if (s_sop) begin
         crc_start_s = CRC_INIT;
         mode_eff_s  = mode;
      end else begin
         crc_start_s = crc_q;
         mode_eff_s  = mode_q;
      end
   end

   crc32_fold_dw #(
      .DATA_W (DATA_W)
   ) u_fold (
      .crc_in  (crc_start_s),
      .keep    (keep_run_s),
      .data    (s_data),
      .crc_out (crc_fold_s)
   );

   // Framing FSM and result generation; a sop always restarts from CRC_INIT.
   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      mode_d      = mode_q;
      fcs_d       = fcs_q;
      fcs_ok_d    = fcs_ok_q;
      fcs_valid_d = 1'b0;
      proto_err_d = 1'b0;
      if (crc_clr) begin
         state_d = IDLE;
         crc_d   = CRC_INIT;
      end else if (s_valid && (s_sop || (state_q == ACTIVE))) begin
         proto_err_d = ~keep_legal_s | (s_sop & (state_q == ACTIVE));
         if (s_sop) begin
            mode_d = mode;
         end else begin
            mode_d = mode_q;
         end
         if (s_eop) begin
            state_d     = IDLE;
            crc_d       = CRC_INIT;
            fcs_valid_d = 1'b1;
            fcs_d       = ~crc_fold_s;
            fcs_ok_d    = mode_eff_s & (crc_fold_s == CRC32_RESIDUE);
         end else begin
            state_d = ACTIVE;
            crc_d   = crc_fold_s;
         end
      end else if (s_valid) begin
         // Stray beat outside a frame: dropped.
         proto_err_d = 1'b1;
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         crc_q       <= CRC_INIT;
         mode_q      <= 1'b0;
         fcs_q       <= 32'h00000000;
         fcs_valid_q <= 1'b0;
         fcs_ok_q    <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         mode_q      <= mode_d;
         fcs_q       <= fcs_d;
         fcs_valid_q <= fcs_valid_d;
         fcs_ok_q    <= fcs_ok_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign crc_state = crc_q;
   assign fcs       = fcs_q;
   assign fcs_valid = fcs_valid_q;
   assign fcs_ok    = fcs_ok_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_crc32_dw_frame.sv
// Self-checking bench for crc32_dw_frame: byte-wide and 32-bit instances
// against a byte-queue CRC-32 reference model.
module tb_crc32_dw_frame;

   typedef logic [7:0] bq_t[$];

   localparam logic [31:0] POLY = 32'hEDB88320;

   logic        clk = 1'b0;
   logic        rst_n, crc_clr, mode;

   logic        v8, sop8, eop8;
   logic [0:0]  keep8;
   logic [7:0]  data8;
   logic [31:0] st8, fcs8;
   logic        fv8, ok8, pe8;

   logic        v32, sop32, eop32;
   logic [3:0]  keep32;
   logic [31:0] data32;
   logic [31:0] st32, fcs32;
   logic        fv32, ok32, pe32;

   int n_cmp = 0;
   int n_bad = 0;

   bq_t digits;

   always #5 clk = ~clk;

   crc32_dw_frame #(.DATA_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .crc_clr(crc_clr), .mode(mode),
      .s_valid(v8), .s_sop(sop8), .s_eop(eop8), .s_keep(keep8), .s_data(data8),
      .crc_state(st8), .fcs_valid(fv8), .fcs(fcs8), .fcs_ok(ok8), .proto_err(pe8)
   );

   crc32_dw_frame #(.DATA_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .crc_clr(crc_clr), .mode(mode),
      .s_valid(v32), .s_sop(sop32), .s_eop(eop32), .s_keep(keep32), .s_data(data32),
      .crc_state(st32), .fcs_valid(fv32), .fcs(fcs32), .fcs_ok(ok32), .proto_err(pe32)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Raw (non-inverted) CRC register after shifting in the bytes, LSB first.
   function automatic logic [31:0] ref_raw(input bq_t q);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         for (int b = 0; b < 8; b++) begin
            if (c[0] ^ q[i][b]) c = (c >> 1) ^ POLY;
            else                c = c >> 1;
         end
      end
      return c;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic beat8(input logic sop, input logic eop, input logic [7:0] d);
      v8 = 1'b1; sop8 = sop; eop8 = eop; keep8 = 1'b1; data8 = d;
      @(negedge clk);
      v8 = 1'b0; sop8 = 1'b0; eop8 = 1'b0;
   endtask

   task automatic beat32(input logic sop, input logic eop, input logic [3:0] k, input logic [31:0] d);
      v32 = 1'b1; sop32 = sop; eop32 = eop; keep32 = k; data32 = d;
      @(negedge clk);
      v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0;
   endtask

   task automatic send8(input bq_t q, input logic m, input logic [31:0] exp_fcs,
                        input logic exp_ok, input string tag);
      mode = m;
      for (int i = 0; i < q.size(); i++) begin
         beat8(i == 0, i == q.size() - 1, q[i]);
         if (i != q.size() - 1) check_eq({tag, "_fv_mid"}, fv8, 1'b0);
      end
      check_eq({tag, "_fv"}, fv8, 1'b1);
      check_eq({tag, "_fcs"}, fcs8, exp_fcs);
      check_eq({tag, "_ok"}, ok8, exp_ok);
      check_eq({tag, "_st"}, st8, 32'hFFFFFFFF);
      check_eq({tag, "_pe"}, pe8, 1'b0);
      idle(1);
      check_eq({tag, "_fv_pulse"}, fv8, 1'b0);
      check_eq({tag, "_fcs_hold"}, fcs8, exp_fcs);
   endtask

   // Sends q as 32-bit beats; the bench derives every expectation from q.
   task automatic send32(input bq_t q, input logic m, input logic gaps, input logic bad,
                         input logic pe_first, input string tag);
      bq_t         pre;
      logic [31:0] raw;
      int          len;
      len  = q.size();
      raw  = ref_raw(q);
      mode = m;
      for (int off = 0; off < len; off += 4) begin
         int          n;
         logic        last, kbad, exp_pe;
         logic [31:0] d;
         logic [3:0]  k;
         n    = (len - off > 4) ? 4 : len - off;
         d    = $urandom();
         k    = 4'b0000;
         last = (off + 4 >= len);
         for (int j = 0; j < n; j++) begin
            d[8*j +: 8] = q[off + j];
            k[j]        = 1'b1;
            pre.push_back(q[off + j]);
         end
         kbad = last && bad && (n <= 2);
         if (kbad) k[n + 1] = 1'b1;
         if (gaps) idle($urandom_range(0, 2));
         beat32(off == 0, last, k, d);
         if (off == 0) mode = 1'($urandom_range(0, 1));
         exp_pe = kbad | ((off == 0) & pe_first);
         check_eq({tag, "_pe"}, pe32, exp_pe);
         if (!last) begin
            check_eq({tag, "_fv_mid"}, fv32, 1'b0);
            check_eq({tag, "_st_mid"}, st32, ref_raw(pre));
         end else begin
            check_eq({tag, "_fv"}, fv32, 1'b1);
            check_eq({tag, "_fcs"}, fcs32, ~raw);
            check_eq({tag, "_ok"}, ok32, m && (raw == 32'hDEBB20E3));
            check_eq({tag, "_st"}, st32, 32'hFFFFFFFF);
         end
      end
   endtask

   initial begin
      bq_t         q;
      logic [31:0] f;
      digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      rst_n = 1'b1; crc_clr = 1'b0; mode = 1'b0;
      v8 = 1'b0; sop8 = 1'b0; eop8 = 1'b0; keep8 = 1'b0; data8 = 8'h00;
      v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0; keep32 = 4'h0; data32 = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_st32", st32, 32'hFFFFFFFF);
      check_eq("rst_fcs32", fcs32, 32'h0);
      check_eq("rst_fv32", fv32, 1'b0);
      check_eq("rst_ok32", ok32, 1'b0);
      check_eq("rst_pe32", pe32, 1'b0);
      check_eq("rst_st8", st8, 32'hFFFFFFFF);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Byte-wide generate and check mode
      send8(digits, 1'b0, 32'hCBF43926, 1'b0, "gen8");
      q = digits;
      q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
      send8(q, 1'b1, 32'h2144DF1C, 1'b1, "chk8");
      q[4] = q[4] ^ 8'h01;
      send8(q, 1'b1, ~ref_raw(q), 1'b0, "chk8_bad");

      // 32-bit: gaps, then malformed eop keep 0101
      send32(digits, 1'b0, 1'b1, 1'b0, 1'b0, "gen32");
      check_eq("gen32_const", fcs32, 32'hCBF43926);
      send32(digits, 1'b0, 1'b1, 1'b1, 1'b0, "keep0101");
      check_eq("keep0101_const", fcs32, 32'hCBF43926);

      // Frame A aborted by sop of frame B
      mode = 1'b0;
      beat32(1'b1, 1'b0, 4'hF, $urandom());
      beat32(1'b0, 1'b0, 4'hF, $urandom());
      beat32(1'b0, 1'b0, 4'hF, $urandom());
      check_eq("abortA_pe", pe32, 1'b0);
      send32(digits, 1'b0, 1'b0, 1'b0, 1'b1, "abortB");
      check_eq("abortB_const", fcs32, 32'hCBF43926);

      // crc_clr on the eop beat, then a stray beat in IDLE
      beat32(1'b1, 1'b0, 4'hF, 32'h34333231);
      crc_clr = 1'b1;
      beat32(1'b0, 1'b1, 4'h1, 32'h00000035);
      crc_clr = 1'b0;
      check_eq("clr_fv", fv32, 1'b0);
      check_eq("clr_st", st32, 32'hFFFFFFFF);
      check_eq("clr_fcs_hold", fcs32, 32'hCBF43926);
      beat32(1'b0, 1'b0, 4'hF, $urandom());
      check_eq("stray_pe", pe32, 1'b1);
      check_eq("stray_st", st32, 32'hFFFFFFFF);
      check_eq("stray_fv", fv32, 1'b0);

      // Asynchronous reset mid-frame
      beat32(1'b1, 1'b0, 4'hF, 32'h34333231);
      beat32(1'b0, 1'b0, 4'hF, 32'h38373635);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_st", st32, 32'hFFFFFFFF);
      check_eq("arst_fcs", fcs32, 32'h0);
      check_eq("arst_fcs8", fcs8, 32'h0);
      check_eq("arst_fv", fv32, 1'b0);
      check_eq("arst_ok", ok32, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send32(digits, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
      check_eq("post_rst_const", fcs32, 32'hCBF43926);

      // Randomised frames, some carrying their own FCS in check mode
      for (int t = 0; t < 40; t++) begin
         logic m, bad;
         int   len;
         q.delete();
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom()));
         m   = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 3) == 0);
         if (m && ($urandom_range(0, 2) != 0)) begin
            f = ~ref_raw(q);
            for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
         end
         send32(q, m, 1'b1, bad, 1'b0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/crc32_dw_frame.md
Name: crc32_dw_frame

Overview:
Parametrised, frame-aware Ethernet CRC-32 engine. It is the successor of the byte-wide crc32_d8.
- Accepts DATA_W-bit beats with byte-keep, sop and eop markers.
- Tracks frame boundaries with a small FSM.
- Generate mode: emits the final on-wire FCS.
- Check mode: flags residue match.
- Sits between MAC TX/RX datapaths and the TRDP/ARP framing logic.

Parameters:
- DATA_W, 32, beat width in bits. Legal values: 8, 16, 32, 64. Derived localparam KEEP_W = DATA_W/8.
- CRC_INIT, 32'hFFFFFFFF, value loaded into the running register at sop, crc_clr and reset.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- crc_clr  in  1  synchronous clear. Highest priority after reset.
- mode  in  1  0 = generate, 1 = check. Sampled on the sop beat and held for the frame.
- s_valid  in  1  beat qualifier. No backpressure: every valid beat is consumed.
- s_sop  in  1  first beat of frame.
- s_eop  in  1  last beat of frame.
- s_keep  in  KEEP_W  byte enables. Bit i qualifies s_data[8i+7:8i].
- s_data  in  DATA_W  byte 0 (bits 7:0) is first on wire. Bits are LSB-first.
- crc_state  out  32  running reflected CRC register (raw, not inverted).
- fcs_valid  out  1  one-cycle pulse: frame result available.
- fcs  out  32  ~crc_final. fcs[7:0] is the first FCS byte on wire. Held until the next fcs_valid.
- fcs_ok  out  1  check mode only: crc_final == 32'hDEBB20E3. Forced 0 in generate mode. Held with fcs.
- proto_err  out  1  one-cycle pulse on a framing/keep violation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, crc_state = CRC_INIT.
  - fcs = 0, fcs_valid = 0, fcs_ok = 0, proto_err = 0.
- Algorithm:
  - Reflected CRC-32, polynomial 32'hEDB88320.
  - Per beat, bytes 0..KEEP_W-1 are folded in ascending order; only bytes with keep = 1 are folded.
  - Whole-beat update completes in one cycle (unrolled).
- FSM states: IDLE, ACTIVE.
  - IDLE, valid & sop & !eop -> ACTIVE. crc_state = fold(CRC_INIT, beat). Latch mode.
  - IDLE, valid & sop & eop -> stay IDLE (single-beat frame). Result issued.
  - IDLE, valid & !sop -> beat dropped, proto_err pulse, crc_state unchanged.
  - ACTIVE, valid & !sop & !eop -> crc_state = fold(crc_state, beat).
  - ACTIVE, valid & eop -> IDLE. Result issued.
  - ACTIVE, valid & sop -> abort the current frame and proto_err pulse. Restart from CRC_INIT with this beat; it follows the IDLE sop rules above. No result is issued for the aborted frame.
  - !s_valid -> hold everything. Gaps of any length are legal.
- Result timing:
  - On the cycle after the eop beat: fcs_valid = 1; fcs = ~crc_final; fcs_ok per mode.
  - crc_state returns to CRC_INIT on the same cycle.
- Keep rules:
  - Non-eop beats require keep all-ones.
  - Eop beats require a thermometer keep from bit 0. All-zero keep is allowed and folds nothing.
  - Violation -> proto_err pulse. Only the lowest contiguous run of set bits is folded.
- crc_clr:
  - Next cycle: state = IDLE, crc_state = CRC_INIT.
  - Any eop beat in the same cycle is discarded: no fcs_valid.
  - fcs and fcs_ok are unchanged.
- An asynchronous reset mid-frame discards the frame. The first sop after release starts cleanly.

Decomposition:
- Package crc32_pkg:
  - CRC32_POLY_REFL = 32'hEDB88320.
  - CRC32_INIT = 32'hFFFFFFFF.
  - CRC32_RESIDUE = 32'hDEBB20E3.
  - function crc32_byte(crc, byte), returning 32 bits.
  - typedef enum {IDLE, ACTIVE} crc_state_e.
- One combinational sub-module, crc32_fold_dw (DATA_W, keep -> next crc), instantiated once. The FSM, registers and outputs stay in the top.

Test Plan:
- DATA_W=8, ASCII "123456789" as 9 beats, sop on the first beat, eop on the last, mode=0 -> one cycle after eop: fcs_valid = 1, fcs = 32'hCBF43926 (fcs[7:0] = 8'h26), crc_state = 32'hFFFFFFFF.
- DATA_W=32, same bytes as 3 beats with final keep = 4'b0001, 2 idle gaps inserted -> fcs = 32'hCBF43926. The same frame with the last beat keep = 4'b0101 -> proto_err pulse, fcs still = 32'hCBF43926.
- Check mode, DATA_W=8, "123456789" followed by 26 39 F4 CB -> fcs_ok = 1, fcs = 32'h2144DF1C. Flip bit 0 of byte '5' -> fcs_ok = 0.
- Frame A (3 beats) interrupted by the sop of frame B = "123456789" -> one proto_err pulse, a single fcs_valid for B only, fcs = 32'hCBF43926.
- crc_clr asserted on the eop beat -> no fcs_valid, crc_state = 32'hFFFFFFFF next cycle, previous fcs held. A valid beat without sop in IDLE -> proto_err, crc_state unchanged.
- rst_n pulsed low mid-frame -> all outputs reach their reset values without a clock edge. The next "123456789" frame yields 32'hCBF43926.
